// File: rtl/mem_store_unit.sv
// mem_store_unit -- store-data select plus store sequencer.
//
// Picks store data from one of NSRC packed sources, latches the request and
// issues it to memory. Word stores go straight to a write; byte and halfword
// stores read the containing word, merge the new lane in and write it back.
// All outputs are registered and cleared by an asynchronous active-high reset.
//
// Ports:
//   clk, reset         clock (rising edge), async active-high reset
//   start              request pulse, only looked at when idle
//   src_sel, src_data  source index and packed sources (source k at [k*DATA_W +: DATA_W])
//   size, addr         00 word / 01 half / 10 byte / 11 reserved, byte address
//   mem_rdata          read data, valid RD_LAT cycles after the mem_rd cycle
//   mem_addr           word-aligned address of the request in flight (0 when idle)
//   mem_wdata          write data, non-zero only in the write cycle
//   mem_rd, mem_wr     one-cycle read / write strobes
//   busy, done, err    status; err pulses together with done on a bad request
module mem_store_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int NSRC   = 2,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [$clog2(NSRC)-1:0]  src_sel,
  input  logic [NSRC*DATA_W-1:0]   src_data,
  input  logic [1:0]               size,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_rd,
  output logic                     mem_wr,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);
  localparam int SEL_W = $clog2(NSRC);
  localparam int CNT_W = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE, S_ERR} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   sel_data_q, sel_data_d;
  logic [1:0]          size_q, size_d;
  logic [1:0]          addr_lo_q, addr_lo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [DATA_W-1:0]   src_pick;
  logic                req_bad;

  // Replace one byte or halfword lane (little-endian) of the read word.
  function automatic logic [DATA_W-1:0] merge_lane(input logic [DATA_W-1:0] base,
                                                   input logic [DATA_W-1:0] d,
                                                   input logic [1:0] sz,
                                                   input logic [1:0] lo);
    logic [DATA_W-1:0] r;
    r = base;
    if (sz == 2'b01) r[{lo[1], 4'b0000} +: 16] = d[15:0];
    else             r[{lo, 3'b000} +: 8]      = d[7:0];
    return r;
  endfunction

  // Out-of-range indices fall back to source 0.
  always_comb begin
    src_pick = src_data[DATA_W-1:0];
    for (int k = 1; k < NSRC; k++)
      if (src_sel == SEL_W'(k)) src_pick = src_data[k*DATA_W +: DATA_W];
  end

  assign req_bad = (size == 2'b11) ||
                   (size == 2'b01 && addr[0]) ||
                   (size == 2'b00 && addr[1:0] != 2'b00);

  // Next-state and next-output logic; outputs are registered on the
  // transition into the state that owns them.
  always_comb begin
    state_d     = state_q;
    sel_data_d  = sel_data_q;
    size_d      = size_q;
    addr_lo_d   = addr_lo_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = '0;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        sel_data_d = src_pick;
        size_d     = size;
        addr_lo_d  = addr[1:0];
        mem_addr_d = {addr[ADDR_W-1:2], 2'b00};
        if (req_bad) begin
          state_d = S_ERR;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (size == 2'b00) begin
          state_d     = S_WRITE;
          mem_wr_d    = 1'b1;
          mem_wdata_d = src_pick;
        end else begin
          state_d  = S_READ;
          mem_rd_d = 1'b1;
        end
      end
      S_READ: begin
        cnt_d   = CNT_W'(RD_LAT);
        state_d = S_WAIT;
      end
      // The write-data register doubles as the read-modify-write buffer:
      // the merged word is formed while mem_rdata is valid.
      S_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d     = S_WRITE;
          mem_wr_d    = 1'b1;
          mem_wdata_d = merge_lane(mem_rdata, sel_data_q, size_q, addr_lo_q);
        end
        cnt_d = cnt_q - CNT_W'(1);
      end
      S_WRITE: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      S_DONE, S_ERR: begin
        state_d    = S_IDLE;
        mem_addr_d = '0;
      end
      default: begin
        state_d    = S_IDLE;
        mem_addr_d = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sel_data_q  <= '0;
      size_q      <= '0;
      addr_lo_q   <= '0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_data_q  <= sel_data_d;
      size_q      <= size_d;
      addr_lo_q   <= addr_lo_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
endmodule

// File: tb/tb_mem_store_unit.sv
// Directed bench for mem_store_unit. Two instances share the request inputs:
// d1 (NSRC=2, RD_LAT=1) and d3 (NSRC=4, RD_LAT=3). Each has a memory model
// that returns the stored word only exactly RD_LAT cycles after mem_rd and
// a poison value otherwise.
module tb_mem_store_unit;
  localparam logic [31:0] MEMW   = 32'h11223344;
  localparam logic [31:0] POISON = 32'hBAD0BAD0;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   sel = '0;
  logic [127:0] src = '0;
  logic [1:0]   size = '0;
  logic [31:0]  addr = '0;

  logic [31:0] rdata1, addr1, wd1, rdata3, addr3, wd3;
  logic        rd1, wr1, busy1, done1, err1, rd3, wr3, busy3, done3, err3;

  int n_chk = 0, n_fail = 0;
  int wr1_n = 0, rd1_n = 0, dn1_n = 0, wr3_n = 0, rd3_n = 0, dn3_n = 0;

  always #5 clk = ~clk;

  mem_store_unit #(.DATA_W(32), .ADDR_W(32), .NSRC(2), .RD_LAT(1)) d1 (
    .clk(clk), .reset(reset), .start(start), .src_sel(sel[0]), .src_data(src[63:0]),
    .size(size), .addr(addr), .mem_rdata(rdata1), .mem_addr(addr1), .mem_wdata(wd1),
    .mem_rd(rd1), .mem_wr(wr1), .busy(busy1), .done(done1), .err(err1));

  mem_store_unit #(.DATA_W(32), .ADDR_W(32), .NSRC(4), .RD_LAT(3)) d3 (
    .clk(clk), .reset(reset), .start(start), .src_sel(sel), .src_data(src),
    .size(size), .addr(addr), .mem_rdata(rdata3), .mem_addr(addr3), .mem_wdata(wd3),
    .mem_rd(rd3), .mem_wr(wr3), .busy(busy3), .done(done3), .err(err3));

  // Memory models: data valid only in the cycle RD_LAT after the mem_rd cycle.
  logic       pipe1 = 1'b0;
  logic [2:0] pipe3 = '0;
  always @(posedge clk) begin
    pipe1 <= rd1;
    pipe3 <= {pipe3[1:0], rd3};
  end
  assign rdata1 = pipe1    ? MEMW : POISON;
  assign rdata3 = pipe3[2] ? MEMW : POISON;

  // Strobe counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr1) wr1_n++;
    if (rd1) rd1_n++;
    if (done1) dn1_n++;
    if (wr3) wr3_n++;
    if (rd3) rd3_n++;
    if (done3) dn3_n++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1; #1;
    n_chk++; if ({rd1, wr1, busy1, done1, err1, addr1, wd1} !== '0) begin n_fail++; $display("FAIL reset_d1: got %h required 0", {rd1, wr1, busy1, done1, err1, addr1, wd1}); end
    n_chk++; if ({rd3, wr3, busy3, done3, err3, addr3, wd3} !== '0) begin n_fail++; $display("FAIL reset_d3: got %h required 0", {rd3, wr3, busy3, done3, err3, addr3, wd3}); end
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_word();
    int r0 = rd1_n;
    src = '0; src[63:32] = 32'hDEADBEEF; sel = 2'd1; size = 2'b00; addr = 32'h100; start = 1'b1;
    step(); start = 1'b0;
    n_chk++; if ({wr1, addr1, wd1} !== {1'b1, 32'h100, 32'hDEADBEEF}) begin n_fail++; $display("FAIL word_write: got wr=%b a=%h d=%h required 1 00000100 deadbeef", wr1, addr1, wd1); end
    n_chk++; if ({busy1, done1} !== 2'b10) begin n_fail++; $display("FAIL word_busy: got busy/done=%b required 10", {busy1, done1}); end
    step();
    n_chk++; if ({done1, err1, wr1, wd1} !== {3'b100, 32'h0}) begin n_fail++; $display("FAIL word_done: got done/err/wr=%b d=%h required 100 0", {done1, err1, wr1}, wd1); end
    step();
    n_chk++; if ({busy1, done1, addr1} !== '0) begin n_fail++; $display("FAIL word_idle: got busy=%b done=%b a=%h required 0", busy1, done1, addr1); end
    n_chk++; if (rd1_n !== r0) begin n_fail++; $display("FAIL word_no_rd: got %0d reads required 0", rd1_n - r0); end
  endtask

  task automatic test_byte_rmw();
    int d0 = dn1_n;
    src = '0; src[31:0] = 32'h000000AB; sel = 2'd0; size = 2'b10; addr = 32'h203; start = 1'b1;
    step(); start = 1'b0; src[31:0] = 32'h000000FF;  // changes after latch must not matter
    n_chk++; if ({rd1, addr1, rd3} !== {1'b1, 32'h200, 1'b1}) begin n_fail++; $display("FAIL byte_read: got rd1=%b a=%h rd3=%b required 1 00000200 1", rd1, addr1, rd3); end
    step();
    n_chk++; if (wr1 !== 1'b0) begin n_fail++; $display("FAIL byte_early_wr: got %b required 0", wr1); end
    step();
    n_chk++; if ({wr1, wd1} !== {1'b1, 32'hAB223344}) begin n_fail++; $display("FAIL byte_write_d1: got wr=%b d=%h required 1 ab223344", wr1, wd1); end
    step();
    n_chk++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL byte_done_d1: got %b required 1", done1); end
    step();
    n_chk++; if ({wr3, wd3} !== {1'b1, 32'hAB223344}) begin n_fail++; $display("FAIL byte_write_d3: got wr=%b d=%h required 1 ab223344", wr3, wd3); end
    step(); step();
    n_chk++; if (dn1_n - d0 !== 1) begin n_fail++; $display("FAIL byte_done_count: got %0d required 1", dn1_n - d0); end
  endtask

  task automatic test_half_rmw();
    src = '0; src[31:0] = 32'h0000CAFE; sel = 2'd0; size = 2'b01; addr = 32'h302; start = 1'b1;
    step(); start = 1'b0;
    n_chk++; if (rd3 !== 1'b1) begin n_fail++; $display("FAIL half_read: got %b required 1", rd3); end
    step(); step(); step();
    n_chk++; if ({wr3, done3} !== 2'b00) begin n_fail++; $display("FAIL half_wait: got wr/done=%b required 00", {wr3, done3}); end
    step();
    n_chk++; if ({wr3, addr3, wd3} !== {1'b1, 32'h300, 32'hCAFE3344}) begin n_fail++; $display("FAIL half_write: got wr=%b a=%h d=%h required 1 00000300 cafe3344", wr3, addr3, wd3); end
    step();
    n_chk++; if (done3 !== 1'b1) begin n_fail++; $display("FAIL half_latency: got done=%b required 1", done3); end
    step();
    n_chk++; if ({busy3, done3} !== 2'b00) begin n_fail++; $display("FAIL half_idle: got %b required 00", {busy3, done3}); end
  endtask

  task automatic test_errors();
    logic [1:0]  sz[3] = '{2'b01, 2'b00, 2'b11};
    logic [31:0] ad[3] = '{32'h1, 32'h2, 32'h40};
    for (int i = 0; i < 3; i++) begin
      int r1 = rd1_n, w1 = wr1_n, r3 = rd3_n, w3 = wr3_n;
      size = sz[i]; addr = ad[i]; start = 1'b1;
      step(); start = 1'b0;
      n_chk++; if ({done1, err1, done3, err3} !== 4'b1111) begin n_fail++; $display("FAIL err_pulse[%0d]: got %b required 1111", i, {done1, err1, done3, err3}); end
      step();
      n_chk++; if ({done3, err3, busy3} !== 3'b000) begin n_fail++; $display("FAIL err_end[%0d]: got %b required 000", i, {done3, err3, busy3}); end
      n_chk++; if ({rd1_n - r1, wr1_n - w1, rd3_n - r3, wr3_n - w3} !== '0) begin n_fail++; $display("FAIL err_strobes[%0d]: got strobes on error request", i); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals[4] = '{32'h5A5A0000, 32'h5A5A1111, 32'h5A5A2222, 32'h5A5A3333};
    int w0 = wr3_n, d0 = dn3_n;
    src = {vals[3], vals[2], vals[1], vals[0]}; size = 2'b00;
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k); addr = 32'h400 + 32'(4 * k); start = 1'b1;
      step();
      n_chk++; if ({wr3, wd3, addr3} !== {1'b1, vals[k], 32'h400 + 32'(4 * k)}) begin n_fail++; $display("FAIL sweep_write[%0d]: got wr=%b d=%h a=%h required %h", k, wr3, wd3, addr3, vals[k]); end
      sel = 2'(k + 1);  // start still high while busy: ignored
      step(); start = 1'b0;
      n_chk++; if (done3 !== 1'b1) begin n_fail++; $display("FAIL sweep_done[%0d]: got %b required 1", k, done3); end
      step();
    end
    n_chk++; if (wr3_n - w0 !== 4) begin n_fail++; $display("FAIL sweep_wr_count: got %0d required 4", wr3_n - w0); end
    n_chk++; if (dn3_n - d0 !== 4) begin n_fail++; $display("FAIL sweep_done_count: got %0d required 4", dn3_n - d0); end
  endtask

  task automatic test_reset_mid();
    int w1, d1c, w3, d3c;
    src = '0; src[31:0] = 32'h00000077; sel = 2'd0; size = 2'b10; addr = 32'h201; start = 1'b1;
    step(); start = 1'b0;
    step();
    w1 = wr1_n; d1c = dn1_n; w3 = wr3_n; d3c = dn3_n;
    reset = 1'b1; #1;
    n_chk++; if ({rd3, wr3, busy3, done3, err3, addr3, wd3} !== '0) begin n_fail++; $display("FAIL midreset_d3: got %h required 0", {rd3, wr3, busy3, done3, err3, addr3, wd3}); end
    n_chk++; if ({rd1, wr1, busy1, done1, err1, addr1, wd1} !== '0) begin n_fail++; $display("FAIL midreset_d1: got %h required 0", {rd1, wr1, busy1, done1, err1, addr1, wd1}); end
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step();
    n_chk++; if ({wr3_n - w3, dn3_n - d3c, wr1_n - w1, dn1_n - d1c} !== '0) begin n_fail++; $display("FAIL midreset_after: got wr3=%0d dn3=%0d wr1=%0d dn1=%0d required 0", wr3_n - w3, dn3_n - d3c, wr1_n - w1, dn1_n - d1c); end
    src = '0; src[95:64] = 32'h12345678; sel = 2'd2; size = 2'b00; addr = 32'h500; start = 1'b1;
    step(); start = 1'b0;
    n_chk++; if ({wr3, wd3, addr3} !== {1'b1, 32'h12345678, 32'h500}) begin n_fail++; $display("FAIL post_reset_write: got wr=%b d=%h a=%h required 1 12345678 00000500", wr3, wd3, addr3); end
    step();
    n_chk++; if (done3 !== 1'b1) begin n_fail++; $display("FAIL post_reset_done: got %b required 1", done3); end
    step();
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_rmw();
    test_half_rmw();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
